// File: rtl/crosscorr_dbg_pkg.sv
// crosscorr_dbg_pkg: shared types and default widths for the crosscorr deadlock reporter.
`default_nettype none

package crosscorr_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } dl_state_t;

    localparam int DEF_NUM_AXIS = 2;
    localparam int DEF_TS_W     = 32;
    localparam int DEF_CNT_W    = 8;

endpackage

`default_nettype wire

// File: rtl/crosscorr_persist_filter.sv
// crosscorr_persist_filter: counts consecutive qualified block samples and flags when the
// run has reached PERSIST_CYCLES-1 already-counted samples.
`default_nettype none

module crosscorr_persist_filter #(
    parameter int PERSIST_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic incr,
    input  logic clear,
    output logic persisted
);

    localparam int CW = $clog2(PERSIST_CYCLES + 1);

    logic [CW-1:0] persist_cnt;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            persist_cnt <= '0;
        end else if (load) begin
            persist_cnt <= CW'(1);
        end else if (incr) begin
            persist_cnt <= persist_cnt + 1'b1;
        end
    end

    // The sample that arrives with this flag set is the final one of the run.
    assign persisted = (persist_cnt == CW'(PERSIST_CYCLES - 1));

endmodule

`default_nettype wire

// File: rtl/crosscorr_deadlock_reporter.sv
// crosscorr_deadlock_reporter: persistence-filtered deadlock declaration with snapshot and irq.
// Optional timestamp counter enabled by defining CROSSCORR_DEADLOCK_TS_EN.
`default_nettype none

module crosscorr_deadlock_reporter
    import crosscorr_dbg_pkg::*;
#(
    parameter int NUM_AXIS       = DEF_NUM_AXIS,
    parameter int PERSIST_CYCLES = 1024,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TS_W           = DEF_TS_W,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                block_in,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                irq_ack,
    output logic                deadlock_irq,
    output logic                deadlock_seen,
    output logic [NUM_AXIS-1:0] block_snapshot,
    output logic [TS_W-1:0]     event_ts,
    output logic [CNT_W-1:0]    event_count
);

    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

    dl_state_t   state, next_state;
    logic        persisted;
    logic        filt_load, filt_incr, filt_clear;
    logic        hold_clr, hold_inc;
    logic        enter_report;
    logic [HOLD_W-1:0] hold_cnt;

    crosscorr_persist_filter #(
        .PERSIST_CYCLES(PERSIST_CYCLES)
    ) u_filter (
        .clock    (clock),
        .reset    (reset),
        .load     (filt_load),
        .incr     (filt_incr),
        .clear    (filt_clear),
        .persisted(persisted)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        filt_load    = 1'b0;
        filt_incr    = 1'b0;
        filt_clear   = 1'b0;
        hold_clr     = 1'b0;
        hold_inc     = 1'b0;
        enter_report = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && block_in) begin
                    next_state = ST_COUNT;
                    filt_load  = 1'b1;
                end
            end
            ST_COUNT: begin
                if (!enable || !block_in) begin
                    next_state = ST_IDLE;
                    filt_clear = 1'b1;
                end else if (persisted) begin
                    next_state   = ST_REPORT;
                    filt_clear   = 1'b1;
                    enter_report = 1'b1;
                end else begin
                    filt_incr = 1'b1;
                end
            end
            ST_REPORT: begin
                // enable is deliberately not looked at: a pending report waits for software.
                if (irq_ack) begin
                    next_state = ST_HOLDOFF;
                    hold_clr   = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (!enable || (hold_cnt == HOLD_W'(HOLDOFF_CYCLES - 1))) begin
                    next_state = ST_IDLE;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || hold_clr) begin
            hold_cnt <= '0;
        end else if (hold_inc) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign deadlock_irq = (state == ST_REPORT);

    always_ff @(posedge clock) begin
        if (reset) begin
            block_snapshot <= '0;
            event_count    <= '0;
            deadlock_seen  <= 1'b0;
        end else if (enter_report) begin
            block_snapshot <= axis_block_sigs;
            deadlock_seen  <= 1'b1;
            if (event_count != {CNT_W{1'b1}}) begin
                event_count <= event_count + 1'b1;
            end
        end
    end

`ifdef CROSSCORR_DEADLOCK_TS_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt   <= '0;
            event_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (enter_report) begin
                event_ts <= ts_cnt;
            end
        end
    end
`else
    assign event_ts = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crosscorr_deadlock_reporter.sv
// tb_crosscorr_deadlock_reporter: randomized + directed stimulus, reference model and scoreboard.
`default_nettype none

module tb_crosscorr_deadlock_reporter;

    localparam int P     = 4;
    localparam int H     = 16;
    localparam int NA    = 2;
    localparam int TSW   = 32;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            block_in = 1'b0;
    logic [NA-1:0]   axis_block_sigs = '0;
    logic            irq_ack = 1'b0;
    logic            deadlock_irq;
    logic            deadlock_seen;
    logic [NA-1:0]   block_snapshot;
    logic [TSW-1:0]  event_ts;
    logic [CW-1:0]   event_count;

    crosscorr_deadlock_reporter #(
        .NUM_AXIS      (NA),
        .PERSIST_CYCLES(P),
        .HOLDOFF_CYCLES(H),
        .TS_W          (TSW),
        .CNT_W         (CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .block_in       (block_in),
        .axis_block_sigs(axis_block_sigs),
        .irq_ack        (irq_ack),
        .deadlock_irq   (deadlock_irq),
        .deadlock_seen  (deadlock_seen),
        .block_snapshot (block_snapshot),
        .event_ts       (event_ts),
        .event_count    (event_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NA-1:0]  snap;
        logic [TSW-1:0] ts;
        int             cnt;
    } rpt_t;

    rpt_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: run length of qualified samples, pending-report flag, holdoff cycles left.
    int             run = 0;
    int             hold_left = 0;
    bit             reporting = 0;
    bit             seen = 0;
    int             count = 0;
    logic [NA-1:0]  m_snap = '0;
    logic [TSW-1:0] m_ts = '0;
    longint         cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit en, input bit blk, input bit ack,
                              input logic [NA-1:0] sigs);
        logic [TSW-1:0] now;
        rpt_t e;
        if (r) begin
            run = 0; hold_left = 0; reporting = 0; seen = 0; count = 0;
            m_snap = '0; m_ts = '0; cycles = 0;
            return;
        end
`ifdef CROSSCORR_DEADLOCK_TS_EN
        now = TSW'(cycles);
`else
        now = '0;
`endif
        cycles++;
        if (reporting) begin
            if (ack) begin
                reporting = 0;
                hold_left = H;
            end
        end else if (hold_left > 0) begin
            if (!en) hold_left = 0;
            else     hold_left--;
        end else if (en && blk) begin
            run++;
            if (run == P) begin
                run = 0;
                reporting = 1;
                seen = 1;
                if (count < CMAX) count++;
                m_snap = sigs;
                m_ts = now;
                e.snap = sigs; e.ts = now; e.cnt = count;
                exp_q.push_back(e);
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit blk, input logic [NA-1:0] sigs,
                       input bit ack);
        reset = r; enable = en; block_in = blk; axis_block_sigs = sigs; irq_ack = ack;
        @(posedge clock);
        model_step(r, en, blk, ack, sigs);
        @(negedge clock);
    endtask

    // Monitor: level checks every cycle, scoreboard pop on each new report.
    bit prev_irq = 0;
    always @(negedge clock) begin
        rpt_t e;
        chk("irq", 64'(deadlock_irq), 64'(reporting));
        chk("seen", 64'(deadlock_seen), 64'(seen));
        chk("snapshot", 64'(block_snapshot), 64'(m_snap));
        chk("count", 64'(event_count), 64'(count));
        chk("ts", 64'(event_ts), 64'(m_ts));
        if (deadlock_irq === 1'b1 && !prev_irq) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_report: got irq=1 expected no report at t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_snapshot", 64'(block_snapshot), 64'(e.snap));
                chk("sb_ts", 64'(event_ts), 64'(e.ts));
                chk("sb_count", 64'(event_count), 64'(e.cnt));
                chk("sb_seen", 64'(deadlock_seen), 64'd1);
            end
        end
        prev_irq = (deadlock_irq === 1'b1);
    end

    initial begin
        bit blk;
        repeat (3) cyc(1, 0, 0, '0, 0);

        // Basic declaration with snapshot 2'b10, then ack and quiet period.
        repeat (P) cyc(0, 1, 1, 2'b10, 0);
        cyc(0, 1, 0, '0, 1);
        repeat (20) cyc(0, 1, 0, '0, 0);

        // Short burst must not declare; full burst after the gap does.
        repeat (P - 1) cyc(0, 1, 1, 2'b01, 0);
        cyc(0, 1, 0, '0, 0);
        repeat (P) cyc(0, 1, 1, 2'b01, 0);

        // Ack while block stays high: holdoff, then a fresh report.
        cyc(0, 1, 1, 2'b11, 1);
        repeat (H + P + 4) cyc(0, 1, 1, 2'b11, 0);
        cyc(0, 1, 1, 2'b00, 1);
        repeat (H) cyc(0, 1, 0, '0, 0);

        // Drive the counter into saturation.
        repeat (3) begin
            repeat (P) cyc(0, 1, 1, NA'($urandom), 0);
            cyc(0, 1, 0, '0, 1);
            repeat (H) cyc(0, 1, 0, '0, 0);
        end

        // Disable during holdoff aborts it early.
        repeat (P) cyc(0, 1, 1, 2'b01, 0);
        cyc(0, 1, 0, '0, 1);
        repeat (2) cyc(0, 1, 0, '0, 0);
        cyc(0, 0, 1, '0, 0);
        repeat (P + 1) cyc(0, 1, 1, 2'b10, 0);
        cyc(0, 1, 0, '0, 1);

        // Reset mid-COUNT and mid-REPORT.
        repeat (2) cyc(0, 1, 1, 2'b01, 0);
        cyc(1, 1, 1, 2'b01, 0);
        repeat (P) cyc(0, 1, 1, 2'b10, 0);
        cyc(0, 0, 0, '0, 0);
        cyc(1, 1, 1, 2'b10, 0);

        // Randomized traffic with bursty block_in.
        blk = 0;
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 8) == 0) blk = ~blk;
            cyc(($urandom % 400) == 0, ($urandom % 20) != 0, blk,
                NA'($urandom), ($urandom % 5) == 0);
        end

        repeat (3) cyc(0, 0, 0, '0, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
